mac_stream: RTL and testbench
=============================

Name: mac_stream

Overview:
- Parametrised, streaming successor to the single-shot 64-input MAC.
- Consumes a dot-product vector as a sequence of LANES-wide beats over a valid/ready handshake and adds an optional bias.
- Accumulates at full precision, then applies optional ReLU and rescales to DATA_W with saturation.
- Presents one result per vector on a held valid/ready output; sits between the layer buffer/weight fetch and the activation writeback in the accelerator.

Parameters:
- LANES, 4: parallel multiply lanes per beat.
- DATA_W, 16: signed width of data, weight, bias and result.
- FRAC_BITS, 8: fractional bits of the fixed-point format (Q(DATA_W-FRAC_BITS).FRAC_BITS).
- ACC_W, 40: signed accumulator width; must be at least 2*DATA_W + log2(LANES*max beats).
- CNT_W, 8: width of the beat counter.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  beat valid
- in_ready  out  1  block can accept a beat
- in_last  in  1  final beat of the vector
- in_data  in  LANES*DATA_W  signed data; lane k = bits [k*DATA_W +: DATA_W]
- in_weight  in  LANES*DATA_W  signed weights, same lane packing
- bias  in  DATA_W  signed bias in the same Q format; sampled on the first beat
- relu_en  in  1  clamp negative results to 0; sampled on the first beat
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  DATA_W  signed, saturated result
- out_sat  out  1  out_data was clipped by saturation
- out_beats  out  CNT_W  number of beats accumulated into out_data

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, accumulator=0, beat count=0, out_valid=0, out_data=0, out_sat=0, out_beats=0. The vector in progress is discarded.
- A beat is accepted when in_valid && in_ready.
- Per-beat arithmetic: lane_sum = sum over k of signed(in_data[k]) * signed(in_weight[k]), sign-extended to ACC_W. Wrap-around at ACC_W is legal but out of spec.
- State IDLE (in_ready=1). On accept:
  - acc <= (sign-extended bias << FRAC_BITS) + lane_sum
  - cnt <= 1
  - relu_en is latched
  - next state = ACCUM, or OUT if in_last=1.
- State ACCUM (in_ready=1). On accept:
  - acc <= acc + lane_sum
  - cnt <= cnt + 1, saturating at all-ones
  - next state = OUT if in_last=1, else stay in ACCUM.
  - Cycles without a beat hold all state.
- Transition into OUT (registered on the same edge that accepts the last beat):
  - out_valid <= 1; out_beats <= final count.
  - Result r = acc arithmetically shifted right by FRAC_BITS (floor, no rounding).
  - If the latched relu_en=1 and r<0, then r=0.
  - If r > 2^(DATA_W-1)-1: out_data = 0x7FFF (for DATA_W=16) and out_sat=1.
  - If r < -2^(DATA_W-1): out_data = 0x8000 and out_sat=1.
  - Otherwise out_data = r and out_sat=0.
- Latency: result is visible the cycle after the last beat is accepted.
- State OUT (in_ready=0):
  - in_valid is ignored; out_data, out_sat and out_beats are held stable while out_ready=0.
  - When out_valid && out_ready: out_valid <= 0, next state = IDLE. in_ready rises the following cycle; there is no same-cycle bypass.
- After a result is consumed, out_data, out_sat and out_beats keep their last values.
- A single beat with in_last=1 in IDLE is a one-beat vector.
- bias and relu_en are ignored on non-first beats.
- in_last is ignored unless the beat is accepted.

Test Plan (LANES=4, DATA_W=16, FRAC_BITS=8):
1. Single beat, all data 0x0100, all weights 0x0100, bias 0, in_last=1 -> out_valid=1 the next cycle, out_data=0x0400, out_sat=0, out_beats=1.
2. Three beats as in test 1 with bias 0x0080, in_last on beat 3, in_valid dropped for 2 cycles between beats 1 and 2 -> out_data=0x0C80, out_beats=3.
3. Saturation:
   - One beat, data 0x7FFF, weights 0x7FFF -> out_data=0x7FFF, out_sat=1.
   - One beat, data 0x8000, weights 0x7FFF -> out_data=0x8000, out_sat=1.
4. ReLU: one beat, data 0xFF00, weights 0x0100:
   - relu_en=0 -> out_data=0xFC00.
   - relu_en=1 -> out_data=0x0000, out_sat=0.
   - relu_en toggled on beat 2 of a two-beat vector -> no effect.
5. Backpressure: hold out_ready=0 for 5 cycles after the result, with in_valid=1 -> out_data stable, in_ready=0, no beat consumed. Then out_ready=1 for one cycle -> out_valid=0 and in_ready=1 on the next cycle.
6. Reset mid-vector: assert reset asynchronously after 2 accepted beats -> out_valid=0 and in_ready=1 immediately after deassertion. A following single-beat vector from test 1 yields exactly 0x0400, with no residue from the discarded beats.

Source files
------------

// File: rtl/mac_stream.sv
// Streaming fixed-point MAC: LANES-wide beats accumulate into one
// saturated DATA_W result per vector, with optional bias and ReLU.
`timescale 1ns/1ps
module mac_stream #(
  parameter int LANES     = 4,
  parameter int DATA_W    = 16,
  parameter int FRAC_BITS = 8,
  parameter int ACC_W     = 40,
  parameter int CNT_W     = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_last,
  input  logic [LANES*DATA_W-1:0]   in_data,
  input  logic [LANES*DATA_W-1:0]   in_weight,
  input  logic [DATA_W-1:0]         bias,
  input  logic                      relu_en,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_sat,
  output logic [CNT_W-1:0]          out_beats
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } state_e;

  localparam int PW = 2 * DATA_W;

  localparam logic signed [ACC_W-1:0] MAX_V =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  state_e state_q, state_d;

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    relu_q, relu_d;
  logic [DATA_W-1:0]       res_q, res_d;
  logic                    sat_q, sat_d;
  logic [CNT_W-1:0]        beats_q, beats_d;

  logic signed [PW-1:0]    prod [LANES];
  logic signed [ACC_W-1:0] lane_sum;
  logic signed [ACC_W-1:0] bias_ext;
  logic signed [ACC_W-1:0] acc_nxt;
  logic signed [ACC_W-1:0] r_shift;
  logic signed [ACC_W-1:0] r_relu;
  logic [CNT_W-1:0]        cnt_nxt;
  logic [DATA_W-1:0]       res_nxt;
  logic                    sat_nxt;
  logic                    first;
  logic                    relu_sel;
  logic                    accept;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign prod[k] =
      $signed(in_data[k*DATA_W +: DATA_W]) *
      $signed(in_weight[k*DATA_W +: DATA_W]);
  end

  always_comb begin
    lane_sum = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_sum = lane_sum +
        {{(ACC_W-PW){prod[k][PW-1]}}, prod[k]};
    end
  end

  // Bias is aligned to the product's 2*FRAC_BITS fraction.
  assign bias_ext = {{(ACC_W-DATA_W-FRAC_BITS){bias[DATA_W-1]}},
                     bias, {FRAC_BITS{1'b0}}};

  assign first    = (state_q == IDLE);
  assign relu_sel = first ? relu_en : relu_q;
  assign acc_nxt  = (first ? bias_ext : acc_q) + lane_sum;
  assign r_shift  = acc_nxt >>> FRAC_BITS;
  assign r_relu   = (relu_sel && r_shift[ACC_W-1]) ? '0 : r_shift;

  always_comb begin
    if (first) begin
      cnt_nxt = CNT_W'(1);
    end else if (&cnt_q) begin
      cnt_nxt = cnt_q;
    end else begin
      cnt_nxt = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    res_nxt = r_relu[DATA_W-1:0];
    sat_nxt = 1'b0;
    unique case (1'b1)
      (r_relu > MAX_V): begin
        res_nxt = {1'b0, {(DATA_W-1){1'b1}}};
        sat_nxt = 1'b1;
      end
      (r_relu < MIN_V): begin
        res_nxt = {1'b1, {(DATA_W-1){1'b0}}};
        sat_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      relu_q  <= 1'b0;
      res_q   <= '0;
      sat_q   <= 1'b0;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      relu_q  <= relu_d;
      res_q   <= res_d;
      sat_q   <= sat_d;
      beats_q <= beats_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    relu_d  = relu_q;
    res_d   = res_q;
    sat_d   = sat_q;
    beats_d = beats_q;
    unique case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          acc_d  = acc_nxt;
          cnt_d  = cnt_nxt;
          relu_d = relu_sel;
          if (in_last) begin
            state_d = OUT;
            res_d   = res_nxt;
            sat_d   = sat_nxt;
            beats_d = cnt_nxt;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      OUT: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q != OUT);
    out_valid = (state_q == OUT);
    accept    = in_valid && in_ready;
    out_data  = res_q;
    out_sat   = sat_q;
    out_beats = beats_q;
  end

endmodule

// File: tb/tb_mac_stream.sv
// Scoreboard bench for mac_stream: expected results are queued
// as vectors are driven and popped when the result appears.
`timescale 1ns/1ps
module tb_mac_stream;

  localparam int L  = 4;
  localparam int DW = 16;
  localparam int CW = 8;

  typedef struct packed {
    logic [15:0] d;
    logic        s;
    logic [7:0]  b;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic            in_last;
  logic [L*DW-1:0] in_data;
  logic [L*DW-1:0] in_weight;
  logic [DW-1:0]   bias;
  logic            relu_en;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic            out_sat;
  logic [CW-1:0]   out_beats;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mac_stream dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .in_data   (in_data),
    .in_weight (in_weight),
    .bias      (bias),
    .relu_en   (relu_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .out_beats (out_beats)
  );

  function automatic logic [63:0] rep(input logic [15:0] v);
    return {4{v}};
  endfunction

  function automatic longint lsum(input logic [63:0] d,
                                  input logic [63:0] w);
    longint s = 0;
    for (int k = 0; k < 4; k++) begin
      s += longint'($signed(d[k*16 +: 16])) *
           longint'($signed(w[k*16 +: 16]));
    end
    return s;
  endfunction

  function automatic exp_t model(input longint acc,
                                 input bit relu, input int nb);
    longint r;
    exp_t e;
    r = acc >>> 8;
    if (relu && r < 0) r = 0;
    if (r > 32767) begin
      e.d = 16'h7FFF; e.s = 1'b1;
    end else if (r < -32768) begin
      e.d = 16'h8000; e.s = 1'b1;
    end else begin
      e.d = r[15:0];  e.s = 1'b0;
    end
    e.b = nb[7:0];
    return e;
  endfunction

  task automatic send_beat(input logic [63:0] d, input logic [63:0] w,
                           input logic [15:0] b, input logic relu,
                           input logic last, input int gap);
    int n = 0;
    in_data   = d;
    in_weight = w;
    bias      = b;
    relu_en   = relu;
    in_last   = last;
    in_valid  = 1'b1;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL in_ready_timeout got=0 exp=1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_out(output bit to);
    int n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    to = !out_valid;
  endtask

  task automatic ack();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_data = '0; in_weight = '0; bias = '0;
    relu_en = 1'b0; out_ready = 1'b0;
    #12;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_hs got rdy=%b vld=%b exp rdy=1 vld=0",
               in_ready, out_valid);
    end
    checks++;
    if ({out_data, out_sat, out_beats} !== 25'd0) begin
      failures++;
      $display("FAIL reset_out got=%h/%b/%0d exp=0/0/0",
               out_data, out_sat, out_beats);
    end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    bit to; exp_t e, got;
    sb.push_back('{16'h0400, 1'b0, 8'd1});
    send_beat(rep(16'h0100), rep(16'h0100), 16'h0, 1'b0, 1'b1, 0);
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL single_latency got=%b exp=1", out_valid);
    end
    wait_out(to);
    e = sb.pop_front(); got = {out_data, out_sat, out_beats};
    checks++;
    if (to || got !== e) begin
      failures++;
      $display("FAIL single got=%h exp=%h", got, e);
    end
    ack();
  endtask

  task automatic test_multi_gap();
    bit to; exp_t e, got;
    sb.push_back('{16'h0C80, 1'b0, 8'd3});
    send_beat(rep(16'h0100), rep(16'h0100), 16'h0080, 1'b0, 1'b0, 2);
    send_beat(rep(16'h0100), rep(16'h0100), 16'h1234, 1'b1, 1'b0, 0);
    send_beat(rep(16'h0100), rep(16'h0100), 16'h7777, 1'b1, 1'b1, 0);
    wait_out(to);
    e = sb.pop_front(); got = {out_data, out_sat, out_beats};
    checks++;
    if (to || got !== e) begin
      failures++;
      $display("FAIL multi_gap got=%h exp=%h", got, e);
    end
    ack();
  endtask

  task automatic test_saturate();
    bit to; exp_t e, got;
    logic [15:0] dv [2] = '{16'h7FFF, 16'h8000};
    sb.push_back('{16'h7FFF, 1'b1, 8'd1});
    sb.push_back('{16'h8000, 1'b1, 8'd1});
    for (int i = 0; i < 2; i++) begin
      send_beat(rep(dv[i]), rep(16'h7FFF), 16'h0, 1'b0, 1'b1, 0);
      wait_out(to);
      e = sb.pop_front(); got = {out_data, out_sat, out_beats};
      checks++;
      if (to || got !== e) begin
        failures++;
        $display("FAIL saturate_%0d got=%h exp=%h", i, got, e);
      end
      ack();
    end
  endtask

  task automatic test_relu();
    bit to; exp_t e, got;
    sb.push_back('{16'hFC00, 1'b0, 8'd1});
    sb.push_back('{16'h0000, 1'b0, 8'd1});
    sb.push_back('{16'hF800, 1'b0, 8'd2});
    sb.push_back('{16'h0000, 1'b0, 8'd2});
    for (int i = 0; i < 4; i++) begin
      if (i < 2) begin
        send_beat(rep(16'hFF00), rep(16'h0100), 16'h0,
                  i[0], 1'b1, 0);
      end else begin
        send_beat(rep(16'hFF00), rep(16'h0100), 16'h0,
                  i[0], 1'b0, 0);
        send_beat(rep(16'hFF00), rep(16'h0100), 16'h0,
                  !i[0], 1'b1, 0);
      end
      wait_out(to);
      e = sb.pop_front(); got = {out_data, out_sat, out_beats};
      checks++;
      if (to || got !== e) begin
        failures++;
        $display("FAIL relu_%0d got=%h exp=%h", i, got, e);
      end
      ack();
    end
  endtask

  task automatic test_backpressure();
    bit to; exp_t e, got;
    sb.push_back('{16'h0400, 1'b0, 8'd1});
    send_beat(rep(16'h0100), rep(16'h0100), 16'h0, 1'b0, 1'b1, 0);
    wait_out(to);
    e = sb.pop_front();
    in_data = rep(16'h0200); in_weight = rep(16'h0200);
    in_last = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      got = {out_data, out_sat, out_beats};
      checks++;
      if (to || got !== e || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold_%0d got=%h vld=%b exp=%h vld=1",
                 i, got, out_valid, e);
      end
      checks++;
      if (in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_ready_%0d got=%b exp=0", i, in_ready);
      end
    end
    ack();
    in_valid = 1'b0; in_last = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release got vld=%b rdy=%b exp vld=0 rdy=1",
               out_valid, in_ready);
    end
    sb.push_back('{16'h0400, 1'b0, 8'd1});
    send_beat(rep(16'h0100), rep(16'h0100), 16'h0, 1'b0, 1'b1, 0);
    wait_out(to);
    e = sb.pop_front(); got = {out_data, out_sat, out_beats};
    checks++;
    if (to || got !== e) begin
      failures++;
      $display("FAIL bp_after got=%h exp=%h", got, e);
    end
    ack();
  endtask

  task automatic test_reset_mid();
    bit to; exp_t e, got;
    send_beat(rep(16'h0300), rep(16'h0300), 16'h0100, 1'b0, 1'b0, 0);
    send_beat(rep(16'h0300), rep(16'h0300), 16'h0, 1'b0, 1'b0, 0);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
        out_beats !== 8'd0) begin
      failures++;
      $display("FAIL rst_mid got vld=%b rdy=%b beats=%0d exp 0/1/0",
               out_valid, in_ready, out_beats);
    end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_release got vld=%b rdy=%b exp vld=0 rdy=1",
               out_valid, in_ready);
    end
    sb.push_back('{16'h0400, 1'b0, 8'd1});
    send_beat(rep(16'h0100), rep(16'h0100), 16'h0, 1'b0, 1'b1, 0);
    wait_out(to);
    e = sb.pop_front(); got = {out_data, out_sat, out_beats};
    checks++;
    if (to || got !== e) begin
      failures++;
      $display("FAIL rst_after got=%h exp=%h", got, e);
    end
    ack();
  endtask

  task automatic test_random();
    bit to; exp_t e, got;
    longint acc;
    logic [63:0] d, w;
    logic [15:0] b;
    bit relu;
    int nb;
    for (int v = 0; v < 8; v++) begin
      nb   = $urandom_range(1, 4);
      b    = 16'($urandom);
      relu = 1'($urandom);
      acc  = longint'($signed(b)) * 256;
      for (int i = 0; i < nb; i++) begin
        d = {$urandom, $urandom};
        w = {$urandom, $urandom};
        if (v[0]) begin
          d = d >> 4;
          w = w >> 4;
        end
        acc += lsum(d, w);
        send_beat(d, w, (i == 0) ? b : 16'($urandom),
                  (i == 0) ? relu : 1'($urandom),
                  (i == nb - 1), $urandom_range(0, 2));
      end
      sb.push_back(model(acc, relu, nb));
      wait_out(to);
      e = sb.pop_front(); got = {out_data, out_sat, out_beats};
      checks++;
      if (to || got !== e) begin
        failures++;
        $display("FAIL random_%0d got=%h exp=%h", v, got, e);
      end
      ack();
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    fork
      begin
        longint acc;
        logic [63:0] d, w;
        int nb;
        for (int v = 0; v < 4; v++) begin
          nb  = $urandom_range(1, 3);
          acc = 0;
          for (int i = 0; i < nb; i++) begin
            d = {$urandom, $urandom} >> 8;
            w = {$urandom, $urandom} >> 8;
            acc += lsum(d, w);
            send_beat(d, w, 16'h0, 1'b0, (i == nb - 1), 0);
          end
          sb.push_back(model(acc, 1'b0, nb));
        end
      end
      begin
        exp_t e, got;
        int seen = 0;
        int cyc  = 0;
        while (seen < 4 && cyc < 300) begin
          @(negedge clk); cyc++;
          if (out_valid && sb.size() > 0) begin
            e = sb.pop_front();
            got = {out_data, out_sat, out_beats};
            checks++;
            if (got !== e) begin
              failures++;
              $display("FAIL b2b_%0d got=%h exp=%h", seen, got, e);
            end
            seen++;
          end
        end
        checks++;
        if (seen != 4) begin
          failures++;
          $display("FAIL b2b_timeout got=%0d exp=4", seen);
        end
      end
    join
    out_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi_gap();
    test_saturate();
    test_relu();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
